imem_fetch_responder: RTL



---
 rtl/imem_fetch_responder_pkg.sv | 19 +
 rtl/imem_fetch_responder_if.sv | 27 ++
 rtl/imem_fetch_responder_resp_fifo.sv | 70 +++++++
 rtl/imem_fetch_responder.sv | 122 ++++++++++++
 4 files changed

// File: rtl/imem_fetch_responder_pkg.sv
// Shared constants and response record for the instruction-memory responder.
package imem_pkg;

   localparam int IMEM_DEPTH_WORDS = 8192;
   localparam int IMEM_BYTE_LIMIT  = 4 * IMEM_DEPTH_WORDS;
   localparam int IMEM_AW          = 32;
   localparam int IMEM_DW          = 32;

   // Instruction word returned for any fetch that errors.
   localparam logic [IMEM_DW-1:0] NOP_INSTR = 32'h0000_0000;

   // One buffered fetch response, in delivery order.
   typedef struct packed {
      logic [IMEM_DW-1:0] instr;
      logic [IMEM_AW-1:0] pc;
      logic               err;
   } resp_t;

endpackage

// File: rtl/imem_fetch_responder_if.sv
// Fetch request/response and preload bus between the PC stage and the responder.
interface imem_fetch_responder_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          req_valid;
   logic          req_ready;
   logic [AW-1:0] req_pc;
   logic          resp_valid;
   logic          resp_ready;
   logic [DW-1:0] resp_instr;
   logic [AW-1:0] resp_pc;
   logic          resp_err;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;

   modport master (
      output req_valid, req_pc, resp_ready, wr_en, wr_addr, wr_data,
      input  req_ready, resp_valid, resp_instr, resp_pc, resp_err
   );

   modport slave (
      input  req_valid, req_pc, resp_ready, wr_en, wr_addr, wr_data,
      output req_ready, resp_valid, resp_instr, resp_pc, resp_err
   );
endinterface

// File: rtl/imem_fetch_responder_resp_fifo.sv
// Small synchronous FIFO holding fetch responses until the consumer takes them.
// The head reads as all zeros whenever the FIFO is empty.
module resp_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 65
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] store_r [DEPTH];
   logic [PW-1:0]    wr_ptr_r;
   logic [PW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full      = (count_r == CW'(DEPTH));
   assign empty     = (count_r == {CW{1'b0}});
   assign count     = count_r;
   assign push_ok_s = push && !full;
   assign pop_ok_s  = pop && !empty;

   // Entry storage; contents need no reset because the count gates visibility.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         store_r[wr_ptr_r] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Head entry, forced to zero when nothing is buffered.
   always_comb begin
      pop_data = {WIDTH{1'b0}};
      if (empty) begin
         pop_data = {WIDTH{1'b0}};
      end else begin
         pop_data = store_r[rd_ptr_r];
      end
   end
endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: preloadable word store answering PC fetches
// one cycle after acceptance, with a small response buffer for backpressure
// and a sticky halt on out-of-range fetches.
// Optional: define IMEM_FETCH_CNT_EN to add the fetch_cnt successful-fetch counter.
module imem_fetch_responder
   import imem_pkg::*;
#(
   parameter int DEPTH_WORDS = IMEM_DEPTH_WORDS,
   parameter int AW          = IMEM_AW,
   parameter int DW          = IMEM_DW,
   parameter int RESP_DEPTH  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   imem_fetch_responder_if.slave bus,
   output logic                  halted
`ifdef IMEM_FETCH_CNT_EN
   ,
   output logic [31:0]           fetch_cnt
`endif
);
   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam int CW    = $clog2(RESP_DEPTH) + 1;
   localparam int RW    = DW + AW + 1;
   localparam logic [AW-1:0] BYTE_LIMIT_C = AW'(4 * DEPTH_WORDS);

   logic [DW-1:0]    mem_r [DEPTH_WORDS];
   logic             halted_r;
   logic             req_ready_s;
   logic             accept_s;
   logic             oor_s;
   logic             mis_s;
   logic             err_s;
   logic             pop_s;
   logic             fifo_full_s;
   logic             fifo_empty_s;
   logic [CW-1:0]    fifo_count_s;
   logic [IDX_W-1:0] rd_idx_s;
   logic [IDX_W-1:0] wr_idx_s;
   logic [DW-1:0]    rd_word_s;
   logic [RW-1:0]    push_data_s;
   logic [RW-1:0]    head_s;

   // The synchronous read lands directly in the response buffer, so the
   // buffer count alone covers every accepted-but-unpopped fetch.
   assign req_ready_s = !rst && !halted_r && (fifo_count_s < CW'(RESP_DEPTH));
   assign accept_s    = bus.req_valid && req_ready_s;
   assign oor_s       = (bus.req_pc >= BYTE_LIMIT_C);
   assign mis_s       = (bus.req_pc[1:0] != 2'b00);
   assign err_s       = oor_s || mis_s;
   assign rd_idx_s    = bus.req_pc[IDX_W+1:2];
   assign wr_idx_s    = bus.wr_addr[IDX_W+1:2];
   assign pop_s       = !fifo_empty_s && bus.resp_ready;
   assign push_data_s = {err_s, bus.req_pc, rd_word_s};

   // Word selected for the response; erroring fetches never touch the array.
   always_comb begin
      rd_word_s = DW'(NOP_INSTR);
      if (err_s) begin
         rd_word_s = DW'(NOP_INSTR);
      end else begin
         rd_word_s = mem_r[rd_idx_s];
      end
   end

   // Preload port; out-of-range writes are dropped and writes work while halted.
   always_ff @(posedge clk) begin
      if (bus.wr_en && (bus.wr_addr < BYTE_LIMIT_C)) begin
         mem_r[wr_idx_s] <= bus.wr_data;
      end
   end

   // Sticky halt raised by accepting an out-of-range fetch.
   always_ff @(posedge clk) begin
      if (rst) begin
         halted_r <= 1'b0;
      end else if (accept_s && oor_s) begin
         halted_r <= 1'b1;
      end else begin
         halted_r <= halted_r;
      end
   end

   resp_fifo #(
      .DEPTH (RESP_DEPTH),
      .WIDTH (RW)
   ) u_resp_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (accept_s && !fifo_full_s),
      .push_data (push_data_s),
      .pop       (pop_s),
      .pop_data  (head_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s),
      .count     (fifo_count_s)
   );

   assign bus.req_ready  = req_ready_s;
   assign bus.resp_valid = !fifo_empty_s;
   assign bus.resp_err   = head_s[RW-1];
   assign bus.resp_pc    = head_s[RW-2:DW];
   assign bus.resp_instr = head_s[DW-1:0];
   assign halted         = halted_r;

`ifdef IMEM_FETCH_CNT_EN
   logic [31:0] fetch_cnt_r;

   // Count error-free responses taken by the consumer, saturating at all ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt_r <= 32'h0000_0000;
      end else if (pop_s && !head_s[RW-1] && (fetch_cnt_r != 32'hFFFF_FFFF)) begin
         fetch_cnt_r <= fetch_cnt_r + 32'h0000_0001;
      end else begin
         fetch_cnt_r <= fetch_cnt_r;
      end
   end

   assign fetch_cnt = fetch_cnt_r;
`endif
endmodule
